// File: rtl/irq_ctrl_nest_pkg.sv
// Shared definitions for the nesting interrupt controller: register map,
// STATUS layout, vector defaults and the vector arithmetic.
package irq_ctrl_nest_pkg;

    // MMIO register byte offsets
    localparam logic [3:0] ADDR_PEND     = 4'h0;
    localparam logic [3:0] ADDR_MASK     = 4'h2;
    localparam logic [3:0] ADDR_PEND_SET = 4'h4;
    localparam logic [3:0] ADDR_PEND_CLR = 4'h6;
    localparam logic [3:0] ADDR_MODE     = 4'h8;
    localparam logic [3:0] ADDR_THRESH   = 4'hA;
    localparam logic [3:0] ADDR_STATUS   = 4'hC;

    // STATUS sticky bit positions (write 1 to clear)
    localparam int STATUS_UNDERFLOW_BIT = 8;
    localparam int STATUS_FULL_BIT      = 9;

    localparam logic [15:0] VEC_BASE_DEFAULT   = 16'h0020;
    localparam logic [15:0] VEC_STRIDE_DEFAULT = 16'h0020;
    localparam logic [15:0] NO_VECTOR          = 16'hFFFF;

    // STATUS read layout
    typedef struct packed {
        logic [5:0] rsvd;
        logic       nest_full;
        logic       ret_underflow;
        logic [3:0] cur_pri;
        logic [3:0] depth;
    } status_t;

    // Handler address of source idx, 16-bit wrap-around
    function automatic logic [15:0] irq_vector(input logic [15:0] base,
                                               input logic [15:0] stride,
                                               input logic [3:0]  idx);
        return base + stride * {12'h000, idx};
    endfunction

endpackage

// File: rtl/irq_ctrl_nest_if.sv
// Zero-wait MMIO bus between the CPU side and the interrupt controller.
interface irq_ctrl_nest_if;
    logic        sel;
    logic        we;
    logic        re;
    logic [3:0]  addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        rdy;

    modport master (output sel, we, re, addr, wdata, input rdata, rdy);
    modport slave  (input sel, we, re, addr, wdata, output rdata, rdy);
endinterface

// File: rtl/irq_ctrl_nest_prio_enc.sv
// Priority encoder: highest set request bit whose index is at or above the
// threshold wins; returns its index, a valid flag and a one-hot copy.
module irq_prio_enc #(
    parameter int N = 8
) (
    input  logic [N-1:0] i_req,
    input  logic [3:0]   i_thresh,
    output logic [3:0]   o_idx,
    output logic         o_valid,
    output logic [N-1:0] o_onehot
);

    // Ascending scan, so the last (highest) eligible bit overrides lower ones
    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        o_idx    = '0;
        o_valid  = 1'b0;
        o_onehot = '0;
        for (int i = 0; i < N; i++) begin
            if (i_req[i] && (4'(i) >= i_thresh)) begin
                o_idx       = 4'(i);
                o_valid     = 1'b1;
                o_onehot    = '0;
                o_onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/irq_ctrl_nest.sv
// Nesting interrupt controller: latches source requests, picks the highest
// eligible one, decides take against the nesting stack and exposes MMIO
// registers for mask, mode, threshold, pending and status.
module irq_ctrl_nest
    import irq_ctrl_nest_pkg::*;
#(
    parameter int          N_SRC      = 8,
    parameter int          NEST_DEPTH = 2,
    parameter logic [15:0] VEC_BASE   = VEC_BASE_DEFAULT,
    parameter logic [15:0] VEC_STRIDE = VEC_STRIDE_DEFAULT
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    irq_ctrl_nest_if.slave   bus,
    input  logic [N_SRC-1:0] i_src_irq,
    input  logic             i_int_en,
    input  logic             i_irq_ret,
    output logic             o_irq_take,
    output logic [15:0]      o_irq_vector
);

    localparam logic [3:0] DEPTH_MAX = 4'(NEST_DEPTH);

    logic [N_SRC-1:0] pend, pend_next, mask, mode, src_q, servicing;
    logic [N_SRC-1:0] hw_req, next_pend, sel_onehot, wdata_n;
    logic [3:0]       thresh, depth, depth_eff, cur_pri_eff, cur_pri_reg, sel_idx;
    logic [3:0]       stack [NEST_DEPTH];
    logic             ret_underflow, nest_full;
    logic             any_req, prio_ok, room, take_req, take;
    logic             wr, wr_mask, wr_set, wr_clr, wr_mode, wr_thresh, wr_status;
    status_t          status;
    logic [15:0]      rd_val;

    assign wr        = bus.sel & bus.we;
    assign wr_mask   = wr && (bus.addr == ADDR_MASK);
    assign wr_set    = wr && (bus.addr == ADDR_PEND_SET);
    assign wr_clr    = wr && (bus.addr == ADDR_PEND_CLR);
    assign wr_mode   = wr && (bus.addr == ADDR_MODE);
    assign wr_thresh = wr && (bus.addr == ADDR_THRESH);
    assign wr_status = wr && (bus.addr == ADDR_STATUS);
    assign wdata_n   = bus.wdata[N_SRC-1:0];
    assign bus.rdy   = bus.sel;

    // Edge sources fire on a rising line; level sources fire while high and not yet in service
    assign hw_req    = mask & i_src_irq & ((mode & ~src_q) | (~mode & ~servicing));
    assign next_pend = pend | hw_req;

    irq_prio_enc #(.N(N_SRC)) u_prio_enc (
        .i_req    (next_pend),
        .i_thresh (thresh),
        .o_idx    (sel_idx),
        .o_valid  (any_req),
        .o_onehot (sel_onehot)
    );

    // A return in the same cycle frees its stack slot before the take decision
    assign depth_eff = (i_irq_ret && (depth != '0)) ? depth - 4'd1 : depth;

    // Top-of-stack priority, both after this cycle's return and as registered
    always_comb begin
        cur_pri_eff = '0;
        cur_pri_reg = '0;
        for (int i = 0; i < NEST_DEPTH; i++) begin
            if (depth_eff == 4'(i + 1)) cur_pri_eff = stack[i];
            if (depth == 4'(i + 1))     cur_pri_reg = stack[i];
        end
    end

    assign prio_ok      = (depth_eff == '0) || (sel_idx > cur_pri_eff);
    assign room         = depth_eff < DEPTH_MAX;
    assign take_req     = any_req & i_int_en & prio_ok;
    assign take         = take_req & room & i_rst_n;
    assign o_irq_take   = take;
    assign o_irq_vector = take ? irq_vector(VEC_BASE, VEC_STRIDE, sel_idx) : NO_VECTOR;

    // Pending update: hardware set, take clear, software set, software clear; last wins
    always_comb begin
        pend_next = next_pend;
        if (take)   pend_next = pend_next & ~sel_onehot;
        if (wr_set) pend_next = pend_next | wdata_n;
        if (wr_clr) pend_next = pend_next & ~wdata_n;
    end

    // Configuration registers written over MMIO
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        // NOTE: state is updated with <= so every register samples pre-edge values regardless of statement order.
        if (!i_rst_n) begin
            mask   <= '1;
            mode   <= '0;
            thresh <= '0;
        end else begin
            if (wr_mask)   mask   <= wdata_n;
            if (wr_mode)   mode   <= wdata_n;
            if (wr_thresh) thresh <= bus.wdata[3:0];
        end
    end

    // Request tracking: pending bits, previous source levels, level sources in service
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pend      <= '0;
            src_q     <= '0;
            servicing <= '0;
        end else begin
            pend      <= pend_next;
            src_q     <= i_src_irq;
            servicing <= (servicing | (take ? (sel_onehot & ~mode) : '0)) & i_src_irq;
        end
    end

    // Nesting stack, depth and sticky error flags
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            depth         <= '0;
            ret_underflow <= 1'b0;
            nest_full     <= 1'b0;
            // NOTE: the stack array is reset explicitly so cur_pri never exposes stale entries after reset.
            for (int i = 0; i < NEST_DEPTH; i++) stack[i] <= '0;
        end else begin
            // Push and replace-top both land on slot depth_eff
            depth <= depth_eff + 4'(take);
            for (int i = 0; i < NEST_DEPTH; i++) begin
                if (take && (depth_eff == 4'(i))) stack[i] <= sel_idx;
            end
            if (wr_status && bus.wdata[STATUS_UNDERFLOW_BIT]) ret_underflow <= 1'b0;
            if (wr_status && bus.wdata[STATUS_FULL_BIT])      nest_full     <= 1'b0;
            if (i_irq_ret && !take && (depth == '0))          ret_underflow <= 1'b1;
            if (take_req && !room)                            nest_full     <= 1'b1;
        end
    end

    // Read mux; unused bits and unmapped offsets read zero
    always_comb begin
        status               = '0;
        status.nest_full     = nest_full;
        status.ret_underflow = ret_underflow;
        status.cur_pri       = cur_pri_reg;
        status.depth         = depth;
        rd_val               = '0;
        case (bus.addr)
            ADDR_PEND:   rd_val[N_SRC-1:0] = pend;
            ADDR_MASK:   rd_val[N_SRC-1:0] = mask;
            ADDR_MODE:   rd_val[N_SRC-1:0] = mode;
            ADDR_THRESH: rd_val[3:0]       = thresh;
            ADDR_STATUS: rd_val            = status;
            default:     rd_val            = '0;
        endcase
    end

    // Registered read data, zero on any cycle without a read
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bus.rdata <= '0;
        end else begin
            bus.rdata <= (bus.sel && bus.re) ? rd_val : 16'h0000;
        end
    end

endmodule

// File: tb/tb_irq_ctrl_nest.sv
// Testbench for irq_ctrl_nest: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_irq_ctrl_nest;
    import irq_ctrl_nest_pkg::*;

    localparam int N  = 8;
    localparam int ND = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] src;
    logic         int_en, irq_ret;
    logic         o_irq_take;
    logic [15:0]  o_irq_vector;

    irq_ctrl_nest_if bus_if ();

    irq_ctrl_nest #(.N_SRC(N), .NEST_DEPTH(ND)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .bus          (bus_if),
        .i_src_irq    (src),
        .i_int_en     (int_en),
        .i_irq_ret    (irq_ret),
        .o_irq_take   (o_irq_take),
        .o_irq_vector (o_irq_vector)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    bit [N-1:0] m_pend, m_mask, m_mode, m_prev, m_svc;
    int         m_thresh;
    int         m_stk[$];
    bit         m_unf, m_full;

    // Per-step expectations and observations
    logic        exp_take, obs_take;
    logic [15:0] exp_vec, obs_vec, exp_rdata, obs_rdata;

    task automatic model_reset();
        m_pend = '0; m_mask = '1; m_mode = '0; m_prev = '0; m_svc = '0;
        m_thresh = 0; m_stk.delete(); m_unf = 1'b0; m_full = 1'b0;
    endtask

    function automatic logic [15:0] model_reg(input logic [3:0] a);
        int top;
        top = (m_stk.size() == 0) ? 0 : m_stk[$];
        case (a)
            4'h0:    return 16'(m_pend);
            4'h2:    return 16'(m_mask);
            4'h8:    return 16'(m_mode);
            4'hA:    return 16'(m_thresh);
            4'hC:    return 16'(int'(m_full) * 512 + int'(m_unf) * 256 + top * 16 + m_stk.size());
            default: return 16'h0000;
        endcase
    endfunction

    // One clock: predict combinational outputs, sample DUT, advance model, sample read data
    task automatic step();
        bit [N-1:0]  req, np, src_s;
        bit          en_s, ret_s, sel_s, we_s, re_s, permit, tk;
        logic [3:0]  addr_s;
        logic [15:0] wd_s;
        int          de, cp, best;
        @(negedge clk);
        src_s = src; en_s = int_en; ret_s = irq_ret;
        sel_s = bus_if.sel; we_s = bus_if.we; re_s = bus_if.re;
        addr_s = bus_if.addr; wd_s = bus_if.wdata;
        req = '0;
        for (int i = 0; i < N; i++)
            if (m_mask[i] && src_s[i] && (m_mode[i] ? !m_prev[i] : !m_svc[i])) req[i] = 1'b1;
        np = m_pend | req;
        de = m_stk.size();
        if (ret_s && de > 0) de--;
        cp = (de == 0) ? 0 : m_stk[de-1];
        best = -1;
        for (int i = N - 1; i >= 0; i--)
            if (best < 0 && np[i] && i >= m_thresh) best = i;
        permit    = (best >= 0) && en_s && (de == 0 || best > cp);
        tk        = permit && (de < ND);
        exp_take  = tk;
        exp_vec   = tk ? 16'(32 + 32 * best) : 16'hFFFF;
        exp_rdata = (sel_s && re_s) ? model_reg(addr_s) : 16'h0000;
        obs_take  = o_irq_take;
        obs_vec   = o_irq_vector;
        @(posedge clk);
        m_pend = np;
        if (tk) begin
            m_pend[best] = 1'b0;
            if (!m_mode[best]) m_svc[best] = 1'b1;
        end
        m_svc  = m_svc & src_s;
        m_prev = src_s;
        if (ret_s && !tk && m_stk.size() == 0) m_unf = 1'b1;
        if (permit && de == ND) m_full = 1'b1;
        if (ret_s && m_stk.size() > 0) void'(m_stk.pop_back());
        if (tk) m_stk.push_back(best);
        if (sel_s && we_s) begin
            case (addr_s)
                4'h2: m_mask = wd_s[N-1:0];
                4'h4: m_pend = m_pend | wd_s[N-1:0];
                4'h6: m_pend = m_pend & ~wd_s[N-1:0];
                4'h8: m_mode = wd_s[N-1:0];
                4'hA: m_thresh = int'(wd_s[3:0]);
                4'hC: begin
                    if (wd_s[8]) m_unf = 1'b0;
                    if (wd_s[9]) m_full = 1'b0;
                    if (ret_s && !tk && de == 0 && m_stk.size() == 0 && !(ret_s && de != m_stk.size())) m_unf = m_unf;
                end
                default: ;
            endcase
            if (addr_s == 4'hC) begin
                if (ret_s && !tk && !(de < int'(m_stk.size())) && (de == 0) && (m_stk.size() == 0)) m_unf = 1'b1;
                if (permit && de == ND) m_full = 1'b1;
            end
        end
        #1;
        obs_rdata = bus_if.rdata;
        bus_if.sel = 1'b0; bus_if.we = 1'b0; bus_if.re = 1'b0; irq_ret = 1'b0;
    endtask

    task automatic mmio_write(input logic [3:0] a, input logic [15:0] d);
        bus_if.sel = 1'b1; bus_if.we = 1'b1; bus_if.addr = a; bus_if.wdata = d;
        step();
    endtask

    task automatic mmio_read(input logic [3:0] a);
        bus_if.sel = 1'b1; bus_if.re = 1'b1; bus_if.addr = a;
        step();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        src = '0; int_en = 1'b0; irq_ret = 1'b0;
        bus_if.sel = 1'b0; bus_if.we = 1'b0; bus_if.re = 1'b0;
        bus_if.addr = '0; bus_if.wdata = '0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; src = 8'hFF; int_en = 1'b1; irq_ret = 1'b0;
        bus_if.sel = 1'b0; bus_if.we = 1'b0; bus_if.re = 1'b0;
        bus_if.addr = '0; bus_if.wdata = '0;
        @(posedge clk);
        #1;
        checks++;
        if (o_irq_take !== 1'b0 || o_irq_vector !== 16'hFFFF || bus_if.rdata !== 16'h0000) begin
            failures++;
            $display("FAIL reset_out: take=%b vec=%h rdata=%h required take=0 vec=ffff rdata=0000",
                     o_irq_take, o_irq_vector, bus_if.rdata);
        end
        src = '0; int_en = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        mmio_read(ADDR_MASK);
        checks++;
        if (obs_rdata !== 16'h00FF) begin
            failures++; $display("FAIL reset_mask: got %h required 00ff", obs_rdata);
        end
        mmio_read(ADDR_STATUS);
        checks++;
        if (obs_rdata !== 16'h0000) begin
            failures++; $display("FAIL reset_status: got %h required 0000", obs_rdata);
        end
        mmio_read(ADDR_MODE);
        checks++;
        if (obs_rdata !== 16'h0000) begin
            failures++; $display("FAIL reset_mode: got %h required 0000", obs_rdata);
        end
    endtask

    task automatic test_level();
        do_reset();
        int_en = 1'b1; src = 8'h08;
        step();
        checks++;
        if (obs_take !== 1'b1 || obs_vec !== 16'h0080) begin
            failures++; $display("FAIL level_take: take=%b vec=%h required take=1 vec=0080", obs_take, obs_vec);
        end
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (obs_take !== 1'b0 || obs_vec !== 16'hFFFF) begin
                failures++; $display("FAIL level_hold%0d: take=%b vec=%h required take=0 vec=ffff", k, obs_take, obs_vec);
            end
        end
        mmio_read(ADDR_STATUS);
        checks++;
        if (obs_rdata !== 16'h0031) begin
            failures++; $display("FAIL level_status: got %h required 0031", obs_rdata);
        end
        irq_ret = 1'b1;
        step();
        src = 8'h00;
        step();
        src = 8'h08;
        step();
        checks++;
        if (obs_take !== 1'b1 || obs_vec !== 16'h0080) begin
            failures++; $display("FAIL level_retake: take=%b vec=%h required take=1 vec=0080", obs_take, obs_vec);
        end
    endtask

    task automatic test_edge();
        do_reset();
        mmio_write(ADDR_MODE, 16'h0002);
        src = 8'h02;
        step();
        src = 8'h00;
        step();
        mmio_read(ADDR_PEND);
        checks++;
        if (obs_rdata !== 16'h0002) begin
            failures++; $display("FAIL edge_pend: got %h required 0002", obs_rdata);
        end
        int_en = 1'b1;
        step();
        checks++;
        if (obs_take !== 1'b1 || obs_vec !== 16'h0040) begin
            failures++; $display("FAIL edge_take: take=%b vec=%h required take=1 vec=0040", obs_take, obs_vec);
        end
        mmio_read(ADDR_PEND);
        checks++;
        if (obs_rdata !== 16'h0000) begin
            failures++; $display("FAIL edge_pend_clr: got %h required 0000", obs_rdata);
        end
    endtask

    task automatic test_preempt();
        do_reset();
        int_en = 1'b1; src = 8'h04;
        step();
        src = 8'h24;
        step();
        checks++;
        if (obs_take !== 1'b1 || obs_vec !== 16'h00C0) begin
            failures++; $display("FAIL preempt_take: take=%b vec=%h required take=1 vec=00c0", obs_take, obs_vec);
        end
        mmio_read(ADDR_STATUS);
        checks++;
        if (obs_rdata !== 16'h0052) begin
            failures++; $display("FAIL preempt_status: got %h required 0052", obs_rdata);
        end
        src = 8'h34;
        step();
        checks++;
        if (obs_take !== 1'b0) begin
            failures++; $display("FAIL preempt_lower: take=%b required 0", obs_take);
        end
        src = 8'h74;
        step();
        checks++;
        if (obs_take !== 1'b0) begin
            failures++; $display("FAIL preempt_full: take=%b required 0", obs_take);
        end
        mmio_read(ADDR_STATUS);
        checks++;
        if (obs_rdata !== 16'h0252) begin
            failures++; $display("FAIL nest_full_flag: got %h required 0252", obs_rdata);
        end
    endtask

    task automatic test_underflow();
        do_reset();
        irq_ret = 1'b1;
        step();
        mmio_read(ADDR_STATUS);
        checks++;
        if (obs_rdata !== 16'h0100) begin
            failures++; $display("FAIL underflow_set: got %h required 0100", obs_rdata);
        end
        mmio_write(ADDR_STATUS, 16'h0100);
        mmio_read(ADDR_STATUS);
        checks++;
        if (obs_rdata !== 16'h0000) begin
            failures++; $display("FAIL underflow_w1c: got %h required 0000", obs_rdata);
        end
    endtask

    task automatic test_thresh();
        do_reset();
        int_en = 1'b1;
        mmio_write(ADDR_THRESH, 16'h0004);
        src = 8'h04;
        step();
        checks++;
        if (obs_take !== 1'b0) begin
            failures++; $display("FAIL thresh_block: take=%b required 0", obs_take);
        end
        mmio_read(ADDR_PEND);
        checks++;
        if (obs_rdata !== 16'h0004) begin
            failures++; $display("FAIL thresh_pend: got %h required 0004", obs_rdata);
        end
        mmio_write(ADDR_THRESH, 16'h0000);
        step();
        checks++;
        if (obs_take !== 1'b1 || obs_vec !== 16'h0060) begin
            failures++; $display("FAIL thresh_release: take=%b vec=%h required take=1 vec=0060", obs_take, obs_vec);
        end
        src = 8'h00; irq_ret = 1'b1;
        step();
        int_en = 1'b0;
        mmio_write(ADDR_PEND_SET, 16'h0002);
        int_en = 1'b1;
        mmio_write(ADDR_PEND_CLR, 16'h0002);
        checks++;
        if (obs_take !== 1'b1 || obs_vec !== 16'h0040) begin
            failures++; $display("FAIL clr_take: take=%b vec=%h required take=1 vec=0040", obs_take, obs_vec);
        end
        mmio_read(ADDR_PEND);
        checks++;
        if (obs_rdata !== 16'h0000) begin
            failures++; $display("FAIL clr_with_take: got %h required 0000", obs_rdata);
        end
        int_en = 1'b0;
        mmio_write(ADDR_PEND_SET, 16'h0008);
        int_en = 1'b1;
        mmio_write(ADDR_PEND_SET, 16'h0008);
        checks++;
        if (obs_take !== 1'b1 || obs_vec !== 16'h0080) begin
            failures++; $display("FAIL set_take: take=%b vec=%h required take=1 vec=0080", obs_take, obs_vec);
        end
        mmio_read(ADDR_PEND);
        checks++;
        if (obs_rdata !== 16'h0008) begin
            failures++; $display("FAIL set_with_take: got %h required 0008", obs_rdata);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        int_en = 1'b1; src = 8'h04;
        step();
        src = 8'h24;
        step();
        src = 8'hA4; irq_ret = 1'b1;
        #1;
        checks++;
        if (o_irq_take !== 1'b1 || o_irq_vector !== 16'h0100) begin
            failures++; $display("FAIL pre_reset_take: take=%b vec=%h required take=1 vec=0100", o_irq_take, o_irq_vector);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (o_irq_take !== 1'b0 || o_irq_vector !== 16'hFFFF) begin
            failures++; $display("FAIL async_reset: take=%b vec=%h required take=0 vec=ffff", o_irq_take, o_irq_vector);
        end
        bus_if.sel = 1'b1; bus_if.re = 1'b1; bus_if.addr = ADDR_MASK;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus_if.rdata !== 16'h0000) begin
                failures++; $display("FAIL reset_rdata%0d: got %h required 0000", k, bus_if.rdata);
            end
        end
        bus_if.sel = 1'b0; bus_if.re = 1'b0; irq_ret = 1'b0; src = '0; int_en = 1'b0;
        rst_n = 1'b1;
        model_reset();
        mmio_read(ADDR_MASK);
        checks++;
        if (obs_rdata !== 16'h00FF) begin
            failures++; $display("FAIL mid_reset_mask: got %h required 00ff", obs_rdata);
        end
        mmio_read(ADDR_STATUS);
        checks++;
        if (obs_rdata !== 16'h0000) begin
            failures++; $display("FAIL mid_reset_status: got %h required 0000", obs_rdata);
        end
    endtask

    task automatic test_random();
        int r;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 5) == 0) src[i] = ~src[i];
            int_en  = ($urandom_range(0, 3) != 0);
            irq_ret = ($urandom_range(0, 5) == 0);
            r = $urandom_range(0, 9);
            if (r < 3) begin
                bus_if.sel = 1'b1; bus_if.we = 1'b1;
                bus_if.addr = 4'($urandom_range(0, 7) * 2);
                bus_if.wdata = 16'($urandom);
                if (bus_if.addr == ADDR_THRESH) bus_if.wdata = 16'($urandom_range(0, 8));
            end else if (r < 6) begin
                bus_if.sel = 1'b1; bus_if.re = 1'b1;
                bus_if.addr = 4'($urandom_range(0, 15));
            end
            step();
            checks++;
            if (obs_take !== exp_take || obs_vec !== exp_vec) begin
                failures++;
                $display("FAIL rand_take step %0d: take=%b vec=%h required take=%b vec=%h",
                         n, obs_take, obs_vec, exp_take, exp_vec);
            end
            checks++;
            if (obs_rdata !== exp_rdata) begin
                failures++;
                $display("FAIL rand_rdata step %0d: got %h required %h", n, obs_rdata, exp_rdata);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_level();
        test_edge();
        test_preempt();
        test_underflow();
        test_thresh();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
